// File: rtl/joy_serial_pkg.sv
// joy_serial_pkg: shared word width, default DB15 bit map, map byte extraction helper and slot FSM states
package joy_serial_pkg;
  localparam int JOY_W = 16;
  localparam int MAP_MAX = 63 * 8;
  localparam logic [191:0] DB15_MAP = {
    8'd20, 8'd21, 8'd22, 8'd23, 8'd26, 8'd27, 8'd24, 8'd25,
    8'd10, 8'd11, 8'd8,  8'd9,  8'd19, 8'd18, 8'd17, 8'd16,
    8'd3,  8'd2,  8'd1,  8'd0,  8'd4,  8'd5,  8'd6,  8'd7
  };
  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_t;
  function automatic logic [7:0] map_idx(input logic [MAP_MAX-1:0] map, input int i);
    return map[8*i +: 8];
  endfunction
endpackage

// File: rtl/joy_serial_rd_if.sv
// joy_serial_rd_if: reader bus (en, joy_data in; joy_clk, joy_load, joystick, frame_done out); slave = reader, master = its user
interface joy_serial_rd_if #(parameter int NJOY = 2);
  import joy_serial_pkg::*;
  logic en;
  logic joy_data;
  logic joy_clk;
  logic joy_load;
  logic frame_done;
  logic [NJOY*JOY_W-1:0] joystick;
  modport master (output en, joy_data, input joy_clk, joy_load, joystick, frame_done);
  modport slave (input en, joy_data, output joy_clk, joy_load, joystick, frame_done);
endinterface

// File: rtl/joy_serial_rd_clkgen.sv
// joy_serial_clkgen: divider toggling o_joy_clk every CLKDIV clks; o_rise marks the clk cycle in which o_joy_clk goes 0->1
module joy_serial_clkgen #(
  parameter int CLKDIV = 8
) (
  input  logic clk,
  input  logic rst,
  output logic o_joy_clk,
  output logic o_rise
);
  logic [7:0] r_div;
  logic r_jclk;
  logic w_tc;
  assign w_tc = r_div == 8'(CLKDIV - 1);
  assign o_rise = w_tc && !r_jclk;
  assign o_joy_clk = r_jclk;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
      r_jclk <= 1'b0;
    end else begin
      r_div <= w_tc ? '0 : r_div + 1'b1;
      r_jclk <= w_tc ? !r_jclk : r_jclk;
    end
  end
endmodule

// File: rtl/joy_serial_rd.sv
// joy_serial_rd: 74HC165 chain reader (clk, rst, bus.slave: en, joy_data -> joy_clk, joy_load, joystick, frame_done) with bit map and two-frame filter
module joy_serial_rd
  import joy_serial_pkg::*;
#(
  parameter int CLKDIV = 8,
  parameter int NJOY = 2,
  parameter int NBITS = 24,
  parameter int LEAD = 1,
  parameter logic [NBITS*8-1:0] MAP = DB15_MAP,
  parameter bit ACTLOW = 1'b1,
  parameter bit FILTER = 1'b1
) (
  input logic clk,
  input logic rst,
  joy_serial_rd_if.slave bus
);
  localparam int FRAME = 1 + LEAD + NBITS;
  localparam int W = NJOY * JOY_W;
  localparam int IW = $clog2(W);
  localparam int SW = $clog2(FRAME);
  localparam logic [MAP_MAX-1:0] MAP_X = MAP_MAX'(MAP);
  state_t r_state;
  logic [SW-1:0] r_slot;
  logic [1:0] r_sync;
  logic r_load, r_last, r_done;
  logic [W-1:0] r_shadow, r_prev, r_joy;
  logic w_jclk, w_rise, w_data, w_end;
  logic [7:0] w_idx;
  int w_bi;
  joy_serial_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk(clk),
    .rst(rst),
    .o_joy_clk(w_jclk),
    .o_rise(w_rise)
  );
  assign w_data = r_slot > SW'(LEAD);
  assign w_end = r_slot == SW'(FRAME - 1);
  assign w_bi = w_data ? int'(r_slot) - LEAD - 1 : 0;
  assign w_idx = map_idx(MAP_X, w_bi);
  assign bus.joy_clk = w_jclk;
  assign bus.joy_load = r_load;
  assign bus.joystick = r_joy;
  assign bus.frame_done = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_slot <= '0;
      r_sync <= '0;
      r_load <= 1'b1;
      r_last <= 1'b0;
      r_done <= 1'b0;
      r_shadow <= '0;
      r_prev <= '0;
      r_joy <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.joy_data};
      r_last <= w_rise && r_state == ST_RUN && w_end;
      r_done <= r_last;
      if (r_last) begin
        r_joy <= (!FILTER || r_shadow == r_prev) ? r_shadow : r_joy;
        r_prev <= r_shadow;
      end
      if (w_rise) begin
        if (r_slot == '0) begin
          if (r_state == ST_RUN || bus.en) begin
            r_state <= ST_RUN;
            r_load <= 1'b0;
            r_shadow <= '0;
            r_slot <= SW'(1);
          end
        end else begin
          r_load <= 1'b1;
          if (w_data && w_idx < 8'(W)) r_shadow[w_idx[IW-1:0]] <= r_sync[1] ^ ACTLOW;
          r_slot <= w_end ? '0 : r_slot + 1'b1;
          if (w_end && !bus.en) r_state <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_joy_serial_rd.sv
// tb_joy_serial_rd: shift-register chain model driving three readers, checked against a spec-level map/filter model
module tb_joy_serial_rd;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, da = 1'b1, db = 1'b0;
  logic [23:0] pat_a = '0, cur_a = '0;
  logic [5:0] pat_b = '0, cur_b = '0;
  logic pca = 1'b0, pcb = 1'b0;
  int ka = 100, kb = 100;
  int n_chk = 0, n_err = 0;
  logic [31:0] e0 = '0, e1 = '0, fprev = '0;
  always #5 clk = ~clk;
  joy_serial_rd_if #(.NJOY(2)) if0 (), if1 ();
  joy_serial_rd_if #(.NJOY(1)) if2 ();
  assign if0.en = en;
  assign if1.en = en;
  assign if2.en = en;
  assign if0.joy_data = da;
  assign if1.joy_data = da;
  assign if2.joy_data = db;
  joy_serial_rd #(.FILTER(1'b0)) d0 (.clk(clk), .rst(rst), .bus(if0));
  joy_serial_rd #(.FILTER(1'b1)) d1 (.clk(clk), .rst(rst), .bus(if1));
  joy_serial_rd #(
    .CLKDIV(4), .NJOY(1), .NBITS(6), .LEAD(2),
    .MAP({8'd15, 8'd0, 8'd20, 8'd3, 8'hFF, 8'd3}),
    .ACTLOW(1'b0), .FILTER(1'b0)
  ) d2 (.clk(clk), .rst(rst), .bus(if2));
  always @(negedge clk) begin
    if (if0.joy_clk && !pca) ka = if0.joy_load ? ka + 1 : 0;
    if (!if0.joy_load) cur_a = pat_a;
    if (!if0.joy_clk && pca) da = (ka >= 1 && ka <= 24) ? !cur_a[ka-1] : 1'b1;
    pca = if0.joy_clk;
  end
  always @(negedge clk) begin
    if (if2.joy_clk && !pcb) kb = if2.joy_load ? kb + 1 : 0;
    if (!if2.joy_load) cur_b = pat_b;
    if (!if2.joy_clk && pcb) db = (kb >= 2 && kb <= 7) ? cur_b[kb-2] : 1'b0;
    pcb = if2.joy_clk;
  end
  function automatic logic [31:0] ref_a(input logic [23:0] p);
    int dst [24] = '{7, 6, 5, 4, 0, 1, 2, 3, 16, 17, 18, 19, 9, 8, 11, 10, 25, 24, 27, 26, 23, 22, 21, 20};
    logic [31:0] r = '0;
    for (int i = 0; i < 24; i++) r[dst[i]] = p[i];
    return r;
  endfunction
  function automatic logic [15:0] ref_b(input logic [5:0] p);
    int dst [6] = '{3, 255, 3, 20, 0, 15};
    logic [15:0] r = '0;
    for (int i = 0; i < 6; i++) if (dst[i] < 16) r[dst[i]] = p[i];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input bit b);
    int c = 0;
    @(negedge clk);
    while (!(b ? if2.frame_done : if0.frame_done) && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 1000) chk("done_timeout", 64'(c), 0);
  endtask
  task automatic cyc_to_done(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!if0.frame_done && c < 1000);
  endtask
  task automatic wait_load();
    int c = 0;
    while (if0.joy_load && c < 1000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 1000) chk("load_timeout", 64'(c), 0);
  endtask
  task automatic wait_rises(input int n);
    int c = 0;
    logic p = if0.joy_clk;
    while (n > 0 && c < 2000) begin
      @(negedge clk);
      c++;
      if (if0.joy_clk && !p) n--;
      p = if0.joy_clk;
    end
    if (n > 0) chk("rise_timeout", 64'(n), 0);
  endtask
  task automatic model(input logic [23:0] p);
    logic [31:0] s = ref_a(p);
    e0 = s;
    if (s == fprev) e1 = s;
    fprev = s;
    chk("d0_joy", if0.joystick, e0);
    chk("d1_joy", if1.joystick, e1);
    chk("d1_done", if1.frame_done, 1);
  endtask
  task automatic run_a(input logic [23:0] p);
    pat_a = p;
    wait_done(0);
    model(p);
    @(negedge clk);
    chk("done_pulse", if0.frame_done, 0);
  endtask
  initial begin
    int t_l1 = 0, t_l2 = 0, t_c1 = 0, t_c2 = 0, t_d = 0, low = 0, rises = 0, c = 0;
    logic pl = 1'b1, pc = 1'b0;
    logic [5:0] dir_b [4] = '{6'b000001, 6'b000100, 6'b001010, 6'b110000};
    repeat (4) @(negedge clk);
    chk("rst_clk", if0.joy_clk, 0);
    chk("rst_load", if0.joy_load, 1);
    chk("rst_joy", if0.joystick, 0);
    chk("rst_done", if0.frame_done, 0);
    rst = 1'b0;
    for (int i = 1; i <= 900; i++) begin
      @(negedge clk);
      if (!if0.joy_load && pl) begin
        if (t_l1 == 0) t_l1 = i;
        else if (t_l2 == 0) t_l2 = i;
      end
      if (!if0.joy_load && t_l2 == 0) low++;
      if (if0.joy_clk && !pc) begin
        if (t_c1 == 0) t_c1 = i;
        else if (t_c2 == 0) t_c2 = i;
      end
      if (if0.frame_done && t_d == 0) t_d = i;
      pl = if0.joy_load;
      pc = if0.joy_clk;
    end
    chk("load_low_len", 64'(low), 16);
    chk("load_period", 64'(t_l2 - t_l1), 416);
    chk("jclk_period", 64'(t_c2 - t_c1), 16);
    chk("first_done", 64'(t_d), 409);
    chk("first_joy", if0.joystick, 0);
    wait_done(0);
    run_a(24'h000010);
    chk("p1_right", if0.joystick, 32'h0000_0001);
    run_a(24'h800100);
    chk("p2_right_a", if0.joystick, 32'h0011_0000);
    run_a(24'h0);
    run_a(24'h0);
    run_a(24'h1);
    chk("filt_once", if1.joystick, 0);
    run_a(24'h1);
    chk("filt_twice", if1.joystick, 32'h0000_0080);
    repeat (12) run_a(($urandom_range(0, 2) == 0) ? pat_a : 24'($urandom));
    pat_a = 24'($urandom) | 24'h10;
    wait_load();
    wait_rises(12);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_clk", if0.joy_clk, 0);
    chk("arst_load", if0.joy_load, 1);
    chk("arst_joy0", if0.joystick, 0);
    chk("arst_joy1", if1.joystick, 0);
    chk("arst_done", if0.frame_done, 0);
    rst = 1'b0;
    e0 = '0;
    e1 = '0;
    fprev = '0;
    cyc_to_done(c);
    chk("restart_done", 64'(c), 409);
    model(pat_a);
    @(negedge clk);
    pat_a = 24'($urandom);
    wait_load();
    wait_rises(5);
    en = 1'b0;
    wait_done(0);
    model(pat_a);
    low = 0;
    pc = if0.joy_clk;
    repeat (160) begin
      @(negedge clk);
      if (!if0.joy_load) low++;
      if (if0.joy_clk && !pc) rises++;
      pc = if0.joy_clk;
    end
    chk("idle_load", 64'(low), 0);
    chk("idle_rises", 64'(rises), 10);
    en = 1'b1;
    t_c1 = 0;
    t_l1 = 0;
    pc = if0.joy_clk;
    for (int i = 1; i <= 40 && t_l1 == 0; i++) begin
      @(negedge clk);
      if (if0.joy_clk && !pc && t_c1 == 0) t_c1 = i;
      if (!if0.joy_load) t_l1 = i;
      pc = if0.joy_clk;
    end
    chk("resume_seen", 64'(t_l1 != 0), 1);
    chk("load_on_tick", 64'(t_l1), 64'(t_c1));
    wait_done(0);
    model(pat_a);
    wait_done(1);
    for (int i = 0; i < 12; i++) begin
      pat_b = (i < 4) ? dir_b[i] : 6'($urandom);
      wait_done(1);
      chk("d2_joy", if2.joystick, ref_b(pat_b));
    end
    $display("%0d/%0d checks passed", n_chk - n_err, n_chk);
    $finish;
  end
endmodule
